tdm_demux_4ch: RTL and testbench

Four-channel time-division demultiplexer: the receiving end of the 4:1 channel multiplexer path. It accepts a serial stream of W-bit words, one per slot, tagged with a frame-sync marker on slot 0. It steers each word into the matching channel register and flags each update. It sits downstream of the mux link and presents four parallel, registered channel outputs to the consuming logic.

---
 rtl/tdm_demux_4ch.sv | 161 ++++++++++++++++
 tb/tb_tdm_demux_4ch.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/tdm_demux_4ch.sv
// -----------------------------------------------------------------------------
// tdm_demux_4ch
// Four-channel time-division demultiplexer. A serial stream of W-bit words,
// one per slot, is steered into four channel registers. Slot 0 of each frame
// is tagged with frame_sync. Every output is driven straight from a flop.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   din         incoming slot word (W bits)
//   din_valid   din carries a word this cycle
//   frame_sync  din is slot 0 of a frame (ignored when din_valid=0)
//   dout        channel registers, channel k at dout[k*W +: W]
//   ch_valid    one-cycle pulse, bit k set when channel k was updated
//   slot        index of the next expected slot (0 in IDLE)
//   frame_done  one-cycle pulse when slots 0-3 of a frame have been captured
//   sync_err    one-cycle pulse when frame_sync arrives mid-frame
//   busy        high while a frame is in progress
// -----------------------------------------------------------------------------
module tdm_demux_4ch #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           frame_sync,
  output logic [4*W-1:0] dout,
  output logic [3:0]     ch_valid,
  output logic [1:0]     slot,
  output logic           frame_done,
  output logic           sync_err,
  output logic           busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [4*W-1:0] dout_q, dout_d;
  logic [3:0]     ch_valid_q, ch_valid_d;
  logic [1:0]     slot_q, slot_d;
  logic           frame_done_q, frame_done_d;
  logic           sync_err_q, sync_err_d;
  logic           busy_q, busy_d;

  logic           store_en_s;
  logic [1:0]     store_idx_s;

  // One-hot decode of a channel index into its ch_valid bit.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] r;
    case (idx)
      2'd0:    r = 4'b0001;
      2'd1:    r = 4'b0010;
      2'd2:    r = 4'b0100;
      2'd3:    r = 4'b1000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Next-state and store decision; pulse outputs default low every cycle.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    store_en_s   = 1'b0;
    store_idx_s  = 2'd0;

    if (din_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_sync) begin
            store_en_s  = 1'b1;
            store_idx_s = 2'd0;
            slot_d      = 2'd1;
            state_d     = ST_RUN;
          end else begin
            // Unsynchronised word: dropped silently.
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (frame_sync) begin
            // Resync: restart at slot 0, aborted frame never reports done.
            sync_err_d  = 1'b1;
            store_en_s  = 1'b1;
            store_idx_s = 2'd0;
            slot_d      = 2'd1;
            state_d     = ST_RUN;
          end else begin
            store_en_s  = 1'b1;
            store_idx_s = slot_q;
            if (slot_q == 2'd3) begin
              frame_done_d = 1'b1;
              slot_d       = 2'd0;
              state_d      = ST_IDLE;
            end else begin
              slot_d       = slot_q + 2'd1;
              state_d      = ST_RUN;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          slot_d  = 2'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    busy_d     = (state_d == ST_RUN);
    ch_valid_d = store_en_s ? onehot4(store_idx_s) : 4'b0000;
  end

  // Channel register write: only the addressed channel takes din.
  always_comb begin
    dout_d = dout_q;
    for (int k = 0; k < 4; k++) begin
      if (store_en_s && (store_idx_s == 2'(k))) begin
        dout_d[k*W +: W] = din;
      end else begin
        dout_d[k*W +: W] = dout_q[k*W +: W];
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dout_q       <= '0;
      ch_valid_q   <= 4'b0000;
      slot_q       <= 2'd0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dout_q       <= dout_d;
      ch_valid_q   <= ch_valid_d;
      slot_q       <= slot_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      busy_q       <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign ch_valid   = ch_valid_q;
  assign slot       = slot_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_4ch
// Directed bench for tdm_demux_4ch (W=8). Inputs change on the falling edge;
// outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_tdm_demux_4ch;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [W-1:0]   din;
  logic           din_valid;
  logic           frame_sync;
  logic [4*W-1:0] dout;
  logic [3:0]     ch_valid;
  logic [1:0]     slot;
  logic           frame_done;
  logic           sync_err;
  logic           busy;

  int checks = 0;
  int errors = 0;

  tdm_demux_4ch #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .ch_valid   (ch_valid),
    .slot       (slot),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against hand-computed values.
  task automatic chk_all(input string tag, input logic [31:0] e_dout, input logic [3:0] e_cv,
                         input logic [1:0] e_slot, input logic e_busy, input logic e_fd,
                         input logic e_se);
    chk({tag, ".dout"},       64'(dout),       64'(e_dout));
    chk({tag, ".ch_valid"},   64'(ch_valid),   64'(e_cv));
    chk({tag, ".slot"},       64'(slot),       64'(e_slot));
    chk({tag, ".busy"},       64'(busy),       64'(e_busy));
    chk({tag, ".frame_done"}, 64'(frame_done), 64'(e_fd));
    chk({tag, ".sync_err"},   64'(sync_err),   64'(e_se));
  endtask

  // Apply one cycle of input, then sample just after the rising edge.
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    din        = 8'h00;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 32'h0000_0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Normal back-to-back frame.
    step(1'b1, 1'b1, 8'hA5); chk_all("norm0", 32'h0000_00A5, 4'b0001, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h3C); chk_all("norm1", 32'h0000_3CA5, 4'b0010, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h7E); chk_all("norm2", 32'h007E_3CA5, 4'b0100, 2'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h81); chk_all("norm3", 32'h817E_3CA5, 4'b1000, 2'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00); chk_all("norm_idle", 32'h817E_3CA5, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // frame_sync without din_valid is ignored.
    step(1'b0, 1'b1, 8'hFF); chk_all("sync_novalid", 32'h817E_3CA5, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Gapped frame with two idle cycles between words; slot holds.
    step(1'b1, 1'b1, 8'hA5); chk_all("gap0", 32'h817E_3CA5, 4'b0001, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h55); chk_all("gap0a", 32'h817E_3CA5, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h55); chk_all("gap0b", 32'h817E_3CA5, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h3C); chk_all("gap1", 32'h817E_3CA5, 4'b0010, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h55); chk_all("gap1a", 32'h817E_3CA5, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h55); chk_all("gap1b", 32'h817E_3CA5, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h7E); chk_all("gap2", 32'h817E_3CA5, 4'b0100, 2'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h55); chk_all("gap2a", 32'h817E_3CA5, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h55); chk_all("gap2b", 32'h817E_3CA5, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h81); chk_all("gap3", 32'h817E_3CA5, 4'b1000, 2'd0, 1'b0, 1'b1, 1'b0);

    // Unsynchronised words in IDLE are dropped.
    step(1'b1, 1'b0, 8'h11); chk_all("unsync11", 32'h817E_3CA5, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h22); chk_all("unsync22", 32'h817E_3CA5, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Resync mid-frame.
    step(1'b1, 1'b1, 8'h01); chk_all("rs01", 32'h817E_3C01, 4'b0001, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h02); chk_all("rs02", 32'h817E_0201, 4'b0010, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hAA); chk_all("rsAA", 32'h817E_02AA, 4'b0001, 2'd1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'hBB); chk_all("rsBB", 32'h817E_BBAA, 4'b0010, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hCC); chk_all("rsCC", 32'h81CC_BBAA, 4'b0100, 2'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hDD); chk_all("rsDD", 32'hDDCC_BBAA, 4'b1000, 2'd0, 1'b0, 1'b1, 1'b0);

    // Back-to-back frame: sync on the cycle right after slot 3.
    step(1'b1, 1'b1, 8'h01); chk_all("mid01", 32'hDDCC_BB01, 4'b0001, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h02); chk_all("mid02", 32'hDDCC_0201, 4'b0010, 2'd2, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-frame: outputs clear with no clock edge.
    @(negedge clk);
    din_valid = 1'b0;
    rst       = 1'b1;
    #1;
    chk_all("async_rst", 32'h0000_0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, 1'b1, 8'h10); chk_all("pr10", 32'h0000_0010, 4'b0001, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h20); chk_all("pr20", 32'h0000_2010, 4'b0010, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h30); chk_all("pr30", 32'h0030_2010, 4'b0100, 2'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h40); chk_all("pr40", 32'h4030_2010, 4'b1000, 2'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00); chk_all("pr_idle", 32'h4030_2010, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
